line_burst_adaptor: RTL and testbench

Responder on the L2-facing side of the cache arbiter. Accepts single-cycle-addressed 256-bit line reads and writes (`read_L2`/`write_L2`/`addr_L2`/`wdata_L2`) and returns `resp_L2`/`rdata_L2`. Converts each line request into a 4-beat, 64-bit burst on the physical memory port. It assembles read beats into a line and serialises write lines into beats.

---
 rtl/line_burst_adaptor_pkg.sv | 21 ++
 rtl/line_burst_adaptor.sv | 137 +++++++++++++
 tb/tb_line_burst_adaptor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and constants for the line/burst adaptor: line and beat
// geometry, the rv32i word type, and the line-alignment helper.
package line_burst_adaptor_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = 4;

  typedef logic [31:0]            rv32i_word;
  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [BURST_WIDTH-1:0] beat_t;

  // Byte-offset bits inside one line (5 for a 32-byte line).
  localparam int LINE_OFS = $clog2(LINE_WIDTH / 8);

  // Clear the in-line byte offset so every burst starts on a line boundary.
  function automatic rv32i_word line_align(input rv32i_word a);
    return a & ~rv32i_word'((1 << LINE_OFS) - 1);
  endfunction

endpackage

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: turns one line read/write from the L2 side into a
// BEATS-beat burst on the memory port. Read beats are assembled into the
// line register; write lines are latched there and sliced out beat by beat.
// Optional feature macro: LINE_ADAPTOR_PERF_EN adds completed-line counters
// perf_rd_lines_o / perf_wr_lines_o.
module line_burst_adaptor #(
  parameter int LINE_WIDTH  = line_burst_adaptor_pkg::LINE_WIDTH,
  parameter int BURST_WIDTH = line_burst_adaptor_pkg::BURST_WIDTH,
  parameter int BEATS       = line_burst_adaptor_pkg::BEATS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  input  logic [31:0]            line_addr_i,
  input  logic [LINE_WIDTH-1:0]  line_wdata_i,
  output logic [LINE_WIDTH-1:0]  line_rdata_o,
  output logic                   line_resp_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [31:0]            mem_addr_o,
  output logic [BURST_WIDTH-1:0] mem_wdata_o,
  input  logic [BURST_WIDTH-1:0] mem_rdata_i,
  input  logic                   mem_resp_i
`ifdef LINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]            perf_rd_lines_o,
  output logic [31:0]            perf_wr_lines_o
`endif
);
  import line_burst_adaptor_pkg::*;

  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt;
  rv32i_word             addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  rd_q;      // 1 = burst in flight is a read
  logic                  last_beat;

  assign last_beat = mem_resp_i && (cnt == CNT_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and all outputs; outputs are pure functions of the state so
  // reset forces every one of them to 0 on the following cycle.
  always_comb begin
    state_n      = state;
    line_resp_o  = 1'b0;
    line_rdata_o = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state)
      IDLE: begin
        // Write wins a simultaneous read; the read is simply dropped.
        if (line_write_i)     state_n = WR_BURST;
        else if (line_read_i) state_n = RD_BURST;
      end
      RD_BURST: begin
        mem_read_o = 1'b1;
        mem_addr_o = addr_q;
        if (last_beat) state_n = DONE;
      end
      WR_BURST: begin
        mem_write_o = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = line_q[int'(cnt) * BURST_WIDTH +: BURST_WIDTH];
        if (last_beat) state_n = DONE;
      end
      DONE: begin
        line_resp_o = 1'b1;
        if (rd_q) line_rdata_o = line_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latch, beat counter and line assembly. The line register keeps
  // its contents between transactions; only the outputs are gated.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write_i) begin
            addr_q <= line_align(line_addr_i);
            line_q <= line_wdata_i;
            cnt    <= '0;
            rd_q   <= 1'b0;
          end else if (line_read_i) begin
            addr_q <= line_align(line_addr_i);
            cnt    <= '0;
            rd_q   <= 1'b1;
          end
        end
        RD_BURST: begin
          if (mem_resp_i) begin
            line_q[int'(cnt) * BURST_WIDTH +: BURST_WIDTH] <= mem_rdata_i;
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_BURST: begin
          if (mem_resp_i) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_ADAPTOR_PERF_EN
  // Completed-line counters, bumped in the DONE cycle, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_lines_o <= '0;
      perf_wr_lines_o <= '0;
    end else if (state == DONE) begin
      if (rd_q) perf_rd_lines_o <= perf_rd_lines_o + 32'd1;
      else      perf_wr_lines_o <= perf_wr_lines_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: a per-cycle vector table plus
// hand-written gap, reset-abort and (optional) counter sequences.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp, mem_read, mem_write, mem_resp;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata, mem_rdata;
`ifdef LINE_ADAPTOR_PERF_EN
  logic [31:0]  perf_rd, perf_wr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  line_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .line_read_i(line_read), .line_write_i(line_write),
    .line_addr_i(line_addr), .line_wdata_i(line_wdata),
    .line_rdata_o(line_rdata), .line_resp_o(line_resp),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
`ifdef LINE_ADAPTOR_PERF_EN
    , .perf_rd_lines_o(perf_rd), .perf_wr_lines_o(perf_wr)
`endif
  );

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_0000_AAAA_0001;
  localparam logic [63:0] WB = 64'hBBBB_0000_BBBB_0002;
  localparam logic [63:0] WC = 64'hCCCC_0000_CCCC_0003;
  localparam logic [63:0] WD = 64'hDDDD_0000_DDDD_0004;
  localparam logic [255:0] RL = {B4, B3, B2, B1};
  localparam logic [255:0] WL = {WD, WC, WB, WA};

  typedef struct {
    logic         rst, rd, wr, resp;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [63:0]  rdata;
    logic         e_lresp, e_mrd, e_mwr;
    logic [31:0]  e_addr;
    logic [63:0]  e_wdata;
    logic [255:0] e_line;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic rd, logic wr, logic [31:0] a, logic [255:0] wd,
                              logic rsp, logic [63:0] rdat, logic el, logic emr, logic emw,
                              logic [31:0] ea, logic [63:0] ew, logic [255:0] eline);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.resp = rsp; v.rdata = rdat;
    v.e_lresp = el; v.e_mrd = emr; v.e_mwr = emw; v.e_addr = ea; v.e_wdata = ew; v.e_line = eline;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " line_resp"},  256'(line_resp), 256'(0));
    chk({tag, " line_rdata"}, line_rdata, 256'(0));
    chk({tag, " mem_read"},   256'(mem_read), 256'(0));
    chk({tag, " mem_write"},  256'(mem_write), 256'(0));
    chk({tag, " mem_addr"},   256'(mem_addr), 256'(0));
    chk({tag, " mem_wdata"},  256'(mem_wdata), 256'(0));
  endtask

  // Read one line; beats are k*0x1111.. for k=1..4. gap_len idle cycles are
  // inserted before beat index gap_at. Returns edges from request to resp.
  task automatic run_read(input logic [31:0] a, input int gap_at, input int gap_len,
                          input string tag, output int edges, output logic [255:0] line);
    int beat, idle;
    line_read = 1'b1; line_addr = a; mem_resp = 1'b0;
    tick();
    line_read = 1'b0; line_addr = 32'hFFFF_FFFF;
    edges = 1; beat = 0; idle = 0;
    while (!line_resp && edges < 40) begin
      chk({tag, " hold mem_read"}, 256'(mem_read), 256'(1));
      chk({tag, " hold mem_addr"}, 256'(mem_addr), 256'({a[31:5], 5'b0}));
      if (beat == gap_at && idle < gap_len) begin
        mem_resp = 1'b0; idle++;
      end else if (beat < 4) begin
        mem_resp = 1'b1; mem_rdata = 64'h1111_1111_1111_1111 * 64'(beat + 1); beat++;
      end else begin
        mem_resp = 1'b0;
      end
      tick();
      edges++;
    end
    mem_resp = 1'b0;
    line = line_rdata;
    tick();
    chk({tag, " resp one-cycle"}, 256'(line_resp), 256'(0));
  endtask

  task automatic run_write(input logic [31:0] a, input logic [255:0] wl, input string tag);
    line_write = 1'b1; line_addr = a; line_wdata = wl; mem_resp = 1'b0;
    tick();
    line_write = 1'b0; line_wdata = '0;
    for (int b = 0; b < 4; b++) begin
      chk({tag, " wdata beat"}, 256'(mem_wdata), 256'(wl[b*64 +: 64]));
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    chk({tag, " wr line_resp"}, 256'(line_resp), 256'(1));
    chk({tag, " wr line_rdata"}, line_rdata, 256'(0));
    tick();
  endtask

  initial begin
    int lat;
    logic [255:0] ln;
    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_addr = '0;
    line_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;

    // rst rd wr addr wdata resp rdata | lresp mrd mwr addr wdata line
    vq.push_back(mk(1, 0, 0, 32'h0,        '0, 0, '0, 0, 0, 0, 32'h0,   '0, '0));
    // read 0x1234, back-to-back beats
    vq.push_back(mk(0, 1, 0, 32'h0000_1234, '0, 0, '0, 0, 1, 0, 32'h1220, '0, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, B1, 0, 1, 0, 32'h1220, '0, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, B2, 0, 1, 0, 32'h1220, '0, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, B3, 0, 1, 0, 32'h1220, '0, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, B4, 1, 0, 0, 32'h0,   '0, RL));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, B4, 0, 0, 0, 32'h0,   '0, '0));
    // write 0x40, beats advance only on resp; inputs wiggle mid-burst
    vq.push_back(mk(0, 0, 1, 32'h0000_0040, WL, 0, '0, 0, 0, 1, 32'h40, WA, '0));
    vq.push_back(mk(0, 1, 0, 32'h0000_0999, '0, 0, '0, 0, 0, 1, 32'h40, WA, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 0, 0, 1, 32'h40, WB, '0));
    vq.push_back(mk(0, 0, 1, 32'h0000_0777, '1, 1, '0, 0, 0, 1, 32'h40, WC, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 0, 0, 1, 32'h40, WD, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 1, 0, 0, 32'h0,   '0, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 0, 0, 0, 32'h0,   '0, '0));
    // read and write together: write burst only
    vq.push_back(mk(0, 1, 1, 32'h0000_0085, WL, 0, '0, 0, 0, 1, 32'h80, WA, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 0, 0, 1, 32'h80, WB, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 0, 0, 1, 32'h80, WC, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 0, 0, 1, 32'h80, WD, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, '0, 1, 0, 0, 32'h0,   '0, '0));
    // stray resp in IDLE is ignored
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 1, B3, 0, 0, 0, 32'h0,   '0, '0));
    vq.push_back(mk(0, 0, 0, 32'h0,        '0, 0, '0, 0, 0, 0, 32'h0,   '0, '0));

    foreach (vq[i]) begin
      rst = vq[i].rst; line_read = vq[i].rd; line_write = vq[i].wr;
      line_addr = vq[i].addr; line_wdata = vq[i].wdata;
      mem_resp = vq[i].resp; mem_rdata = vq[i].rdata;
      tick();
      chk($sformatf("v%0d line_resp", i),  256'(line_resp),  256'(vq[i].e_lresp));
      chk($sformatf("v%0d mem_read", i),   256'(mem_read),   256'(vq[i].e_mrd));
      chk($sformatf("v%0d mem_write", i),  256'(mem_write),  256'(vq[i].e_mwr));
      chk($sformatf("v%0d mem_addr", i),   256'(mem_addr),   256'(vq[i].e_addr));
      chk($sformatf("v%0d mem_wdata", i),  256'(mem_wdata),  256'(vq[i].e_wdata));
      chk($sformatf("v%0d line_rdata", i), line_rdata,       vq[i].e_line);
    end
    rst = 1'b0; line_read = 1'b0; line_write = 1'b0; mem_resp = 1'b0;

    // Back-to-back read: request edge + 4 beat edges -> resp visible at edge 5.
    run_read(32'h0000_2000, 9, 0, "nogap", lat, ln);
    chk("nogap latency", 256'(lat), 256'(5));
    chk("nogap line", ln, RL);
    // 3 idle cycles between beats 2 and 3 delay resp by exactly 3.
    run_read(32'h0000_301F, 2, 3, "gap", lat, ln);
    chk("gap latency", 256'(lat), 256'(8));
    chk("gap line", ln, RL);

    // Reset after beat 2 of a read abandons it.
    line_read = 1'b1; line_addr = 32'h0000_0100;
    tick();
    line_read = 1'b0;
    mem_resp = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001; tick();
    mem_rdata = 64'hDEAD_BEEF_0000_0002; tick();
    mem_resp = 1'b0; rst = 1'b1; tick();
    chk_all_zero("rstmid");
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_resp = 1'b1;
      tick();
      chk("rstmid no resp", 256'({line_resp, mem_read}), 256'(0));
    end
    mem_resp = 1'b0;
    run_read(32'h0000_0100, 9, 0, "after rst", lat, ln);
    chk("after rst latency", 256'(lat), 256'(5));
    chk("after rst line", ln, RL);

`ifdef LINE_ADAPTOR_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf rd reset", 256'(perf_rd), 256'(0));
    chk("perf wr reset", 256'(perf_wr), 256'(0));
    run_read(32'h0000_4000, 9, 0, "perf rd1", lat, ln);
    run_write(32'h0000_5000, WL, "perf wr1");
    run_read(32'h0000_6000, 1, 2, "perf rd2", lat, ln);
    chk("perf rd count", 256'(perf_rd), 256'(2));
    chk("perf wr count", 256'(perf_wr), 256'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf rd cleared", 256'(perf_rd), 256'(0));
    chk("perf wr cleared", 256'(perf_wr), 256'(0));
`else
    run_write(32'h0000_5000, WL, "wr task");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
